// File: rtl/ysyx_22050039_ifu.sv
// ysyx_22050039_ifu - instruction fetch stage.
// Owns the PC and keeps at most one instruction-memory request in flight.
// The fetched word and its PC go to decode over a valid/ready handshake.
// A redirect from execute overrides the PC in any state. A response that
// is still owed for a wrong-path fetch is marked with 'squash' and dropped.
// Optional build macro YSYX_22050039_IFU_PERF_EN adds two 64-bit counters:
// perf_fetch_cnt and perf_stall_cnt.
module ysyx_22050039_ifu #(
  parameter int              XLEN     = 64,
  parameter int              INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc
`ifdef YSYX_22050039_IFU_PERF_EN
  ,
  output logic [63:0]         perf_fetch_cnt,
  output logic [63:0]         perf_stall_cnt
`endif
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic            squash;
  logic            started;
  logic            req_fire;

  assign imem_req_valid = started && (state == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_HOLD);
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Keep the request low during reset and for the cycle in which reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  // Fetch FSM. In every state a redirect has priority over memory and decode events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      inst    <= '0;
      inst_pc <= RESET_PC;
      squash  <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
          if (req_fire) begin
            state  <= S_WAIT;
            squash <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (imem_resp_valid) begin
              squash <= 1'b0;
              state  <= S_REQ;
            end else begin
              squash <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (squash) begin
              squash <= 1'b0;
              state  <= S_REQ;
            end else begin
              inst    <= imem_resp_data;
              inst_pc <= pc;
              state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= S_REQ;
          end else if (inst_ready) begin
            pc    <= pc + XLEN'(4);
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

`ifdef YSYX_22050039_IFU_PERF_EN
  logic inst_fire;
  logic stall_cycle;

  assign inst_fire   = inst_valid && inst_ready;
  assign stall_cycle = ((state == S_REQ) || (state == S_WAIT)) && !redirect_valid;

  // Count delivered instructions and the cycles spent waiting on memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (inst_fire) begin
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      end
      if (stall_cycle) begin
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
      end
    end
  end
`else
  // This build has no performance counters.
`endif

endmodule
